aes_ctrl_shadow_writer: RTL and testbench
=========================================

# aes_ctrl_shadow_writer

Initiator-side sequencer for the AES shadowed control register. It accepts one 32-bit control word (`aes_pkg::ctrl_reg_t`), issues the mandatory back-to-back double write to the shadowed register, and waits for each acknowledge. It detects update errors and timeouts, and optionally reads back and compares the committed value. It sits between the AES control/config logic and the shadowed `ctrl` register, and reports one completion pulse with a status code per request.

## Interface
Parameters:
- `TimeoutCycles`, default 16: maximum wait cycles for each `reg_ack_i`; 0 disables the timeout.
- `RESVAL`, default `aes_pkg::CTRL_RESET`: reset value of `committed_o`.

Ports:
- Clock and reset: one clock, `clk_i`; reset `rst_ni` is asynchronous and active-low.
- `clk_i` in 1 — clock.
- `rst_ni` in 1 — asynchronous, active-low reset.
- `req_valid_i` in 1 — new control word is available.
- `req_ready_o` out 1 — block is idle; a request is accepted on `valid && ready`.
- `req_data_i` in 32 — control word to commit.
- `reg_we_o` out 1 — write strobe to the shadowed register, one cycle per write.
- `reg_wdata_o` out 32 — write data; holds the latched request word.
- `reg_ack_i` in 1 — write acknowledge, single-cycle.
- `reg_err_update_i` in 1 — update (mismatch) error from the shadow register; sampled with the second ack only.
- `reg_rdata_i` in 32 — committed value of the shadow register.
- `done_o` out 1 — one-cycle completion pulse.
- `status_o` out 2 — valid when `done_o` is high: 00 OK, 01 update error, 10 timeout, 11 readback mismatch.
- `committed_o` out 32 — last word committed with status OK.

## Operation
- States:
  - IDLE: `req_ready_o`=1.
  - WR1: `reg_we_o`=1.
  - WAIT1.
  - WR2: `reg_we_o`=1, same data.
  - WAIT2.
  - CHECK: only present with the macro.
  - DONE: `done_o`=1.
- Transitions:
  - IDLE→WR1 on accept; `req_data_i` is latched into the data register.
  - WR1→WAIT1 unconditionally.
  - WAIT1→WR2 on `reg_ack_i`.
  - WR2→WAIT2 unconditionally.
  - WAIT2→CHECK (or DONE if the macro is absent) on `reg_ack_i` with `reg_err_update_i`=0.
  - WAIT2→DONE with status 01 on `reg_ack_i` with `reg_err_update_i`=1.
  - WAIT1/WAIT2→DONE with status 10 when the timer reaches `TimeoutCycles`.
  - CHECK→DONE with status 00 if `reg_rdata_i == data`, else status 11.
  - DONE→IDLE unconditionally.
- Ack handling:
  - `reg_ack_i` in any state other than WAIT1/WAIT2 is ignored.
  - `reg_err_update_i` is ignored with the first ack, because the first write only stages the value.
- Timer:
  - Cleared on entry to WAIT1 and WAIT2; increments each WAIT cycle without an ack.
  - Width is `$clog2(TimeoutCycles+1)`; it saturates and does not wrap.
- `committed_o` loads the latched data in DONE only when status is 00; otherwise it holds.
- `req_data_i` changing after accept has no effect.

## Timing
- Reset values:
  - All outputs 0, except `committed_o`=`RESVAL` and `req_ready_o`=1.
  - FSM=IDLE, timer=0, data register=0.
- Best-case latency, with ack on the first WAIT cycle:
  - Accept at cycle 0; `reg_we_o` high in cycles 1 and 3; acks in cycles 2 and 4.
  - CHECK in cycle 5, `done_o` in cycle 6 (cycle 5 without the macro).
- Every request produces exactly one `done_o` pulse; `req_ready_o` is low from the cycle after accept through DONE.
- Back-to-back requests: the next accept is possible in the cycle after DONE.
- Timeout: with no ack, `done_o` asserts `TimeoutCycles`+1 cycles after entering WAIT.
- Reset asserted mid-operation: immediately returns to the reset values, drops `reg_we_o` with no further writes, and emits no `done_o`.

## Configuration
- `AES_SHADOW_READBACK_EN`:
  - Defined: CHECK state present; status 11 reachable.
  - Undefined: no CHECK state; `reg_rdata_i` is unused; WAIT2 ack without error goes directly to DONE with status 00.

## Structure
- `aes_pkg` holds:
  - `ctrl_reg_t` and `CTRL_RESET`.
  - The `shadow_wr_state_e` enum.
  - The `shadow_wr_status_e` enum (OK, UPDATE_ERR, TIMEOUT, MISMATCH).
- Sub-module `aes_shadow_wr_timer`: clear/enable saturating counter with an `expired_o` flag; instantiated once and shared by WAIT1/WAIT2.

## Test plan
- Immediate acks, data 0x0000_00A5:
  - Writes in cycles 1 and 3, `done_o` in cycle 6 with status 00.
  - `committed_o`=0x0000_00A5.
- Second ack with `reg_err_update_i`=1, data 0x1234_5678:
  - Status 01; `committed_o` keeps its previous value.
- `TimeoutCycles`=4, no ack after WR1:
  - Status 10 five cycles after entering WAIT1; no second write issued.
- Macro defined, `reg_rdata_i`=0xDEAD_BEEF vs. data 0xDEAD_BEEE:
  - Status 11.
- Stray ack in IDLE and during WR1:
  - Ignored; sequence otherwise identical to the first scenario.
- `rst_ni` low during WAIT2:
  - `reg_we_o`=0, `req_ready_o`=1, `committed_o`=`RESVAL`, no `done_o` pulse.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the AES shadowed control-register writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    // AES main control word as stored in the shadowed ctrl register.
    typedef struct packed {
        logic [15:0] reserved;
        logic [2:0]  prng_reseed_rate;
        logic        manual_operation;
        logic [2:0]  key_len;
        logic        sideload;
        logic [5:0]  mode;
        logic [1:0]  operation;
    } ctrl_reg_t;

    // Reset image: encrypt, mode NONE, AES-128, reseed rate 1 -> 32'h0000_2281.
    localparam ctrl_reg_t CTRL_RESET = '{
        reserved:         16'h0000,
        prng_reseed_rate: 3'b001,
        manual_operation: 1'b0,
        key_len:          3'b001,
        sideload:         1'b0,
        mode:             6'b10_0000,
        operation:        2'b01
    };

    typedef enum logic [2:0] {
        SW_IDLE  = 3'd0,
        SW_WR1   = 3'd1,
        SW_WAIT1 = 3'd2,
        SW_WR2   = 3'd3,
        SW_WAIT2 = 3'd4,
        SW_CHECK = 3'd5,
        SW_DONE  = 3'd6
    } shadow_wr_state_e;

    typedef enum logic [1:0] {
        SW_OK         = 2'b00,
        SW_UPDATE_ERR = 2'b01,
        SW_TIMEOUT    = 2'b10,
        SW_MISMATCH   = 2'b11
    } shadow_wr_status_e;

endpackage

// File: rtl/aes_shadow_wr_timer.sv
// Saturating wait-cycle counter shared by both acknowledge waits.
// Latency: clear/enable take effect on the next clock; expired_o is combinational from the count.
// Backpressure: none; counts whenever enabled, stops at TimeoutCycles.
// Ports: clk_i, rst_ni (async active-low), clr_i (restart at 0), en_i (count one cycle),
//        expired_o (count reached TimeoutCycles; never asserted when TimeoutCycles == 0).
module aes_shadow_wr_timer #(
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    // A zero timeout still needs a legal one-bit counter; expired_o is masked instead.
    localparam int unsigned TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TW-1:0] MAX_CNT = (TimeoutCycles > 0) ? TW'(TimeoutCycles) : TW'(1);

    logic [TW-1:0] r_cnt;
    logic          w_sat;

    assign w_sat     = (r_cnt == MAX_CNT);
    assign expired_o = (TimeoutCycles != 0) && w_sat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !w_sat) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/aes_ctrl_shadow_writer.sv
// Commits one control word to the shadowed ctrl register via a double write, reporting status.
// Latency: accept->done 5 cycles with immediate acks (6 with AES_SHADOW_READBACK_EN); timeout after TimeoutCycles+1 wait cycles.
// Backpressure: req_ready_o only in IDLE; one request in flight; next accept the cycle after done_o.
// Ports: req_valid_i/req_ready_o/req_data_i request handshake; reg_we_o/reg_wdata_o write port;
//        reg_ack_i/reg_err_update_i/reg_rdata_i shadow-register response; done_o/status_o completion;
//        committed_o last word committed with status OK.
// Option: define AES_SHADOW_READBACK_EN to add the CHECK state comparing reg_rdata_i against the word.
module aes_ctrl_shadow_writer
    import aes_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16,
    parameter ctrl_reg_t   RESVAL        = CTRL_RESET
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_data_i,
    output logic        reg_we_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_ack_i,
    input  logic        reg_err_update_i,
    input  logic [31:0] reg_rdata_i,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [31:0] committed_o
);
    shadow_wr_state_e  r_state;
    shadow_wr_status_e r_status;
    ctrl_reg_t         r_data;
    ctrl_reg_t         r_committed;
    logic              r_ready;
    logic              r_we;
    logic              r_done;

    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_expired;
    logic w_in_wait;

`ifndef AES_SHADOW_READBACK_EN
    logic w_rdata_unused;
    assign w_rdata_unused = ^reg_rdata_i;
`endif

    // Timer restarts during each write cycle so it reads 0 on the first wait cycle.
    assign w_in_wait = (r_state == SW_WAIT1) || (r_state == SW_WAIT2);
    assign w_tmr_clr = (r_state == SW_WR1) || (r_state == SW_WR2);
    assign w_tmr_en  = w_in_wait && !reg_ack_i;

    aes_shadow_wr_timer #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (w_tmr_clr),
        .en_i      (w_tmr_en),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= SW_IDLE;
            r_status    <= SW_OK;
            r_data      <= '0;
            r_committed <= RESVAL;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                SW_IDLE: begin
                    if (req_valid_i && r_ready) begin
                        r_data  <= ctrl_reg_t'(req_data_i);
                        r_ready <= 1'b0;
                        r_we    <= 1'b1;
                        r_state <= SW_WR1;
                    end
                end
                SW_WR1: r_state <= SW_WAIT1;
                SW_WAIT1: begin
                    // The first write only stages the value, so its error flag carries no meaning.
                    if (reg_ack_i) begin
                        r_we    <= 1'b1;
                        r_state <= SW_WR2;
                    end else if (w_expired) begin
                        r_status <= SW_TIMEOUT;
                        r_done   <= 1'b1;
                        r_state  <= SW_DONE;
                    end
                end
                SW_WR2: r_state <= SW_WAIT2;
                SW_WAIT2: begin
                    if (reg_ack_i) begin
                        if (reg_err_update_i) begin
                            r_status <= SW_UPDATE_ERR;
                            r_done   <= 1'b1;
                            r_state  <= SW_DONE;
                        end else begin
`ifdef AES_SHADOW_READBACK_EN
                            r_state  <= SW_CHECK;
`else
                            r_status <= SW_OK;
                            r_done   <= 1'b1;
                            r_state  <= SW_DONE;
`endif
                        end
                    end else if (w_expired) begin
                        r_status <= SW_TIMEOUT;
                        r_done   <= 1'b1;
                        r_state  <= SW_DONE;
                    end
                end
`ifdef AES_SHADOW_READBACK_EN
                SW_CHECK: begin
                    r_status <= (ctrl_reg_t'(reg_rdata_i) == r_data) ? SW_OK : SW_MISMATCH;
                    r_done   <= 1'b1;
                    r_state  <= SW_DONE;
                end
`endif
                SW_DONE: begin
                    if (r_status == SW_OK) begin
                        r_committed <= r_data;
                    end
                    r_ready <= 1'b1;
                    r_state <= SW_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= SW_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign reg_we_o    = r_we;
    assign reg_wdata_o = r_data;
    assign done_o      = r_done;
    assign status_o    = r_status;
    assign committed_o = r_committed;

endmodule

// File: tb/tb_aes_ctrl_shadow_writer.sv
// Scoreboard bench for aes_ctrl_shadow_writer: stimulus pushes expected writes and completions,
// a negedge monitor pops and compares them. Optional readback scenario follows AES_SHADOW_READBACK_EN.
module tb_aes_ctrl_shadow_writer;

    localparam int unsigned TO = 4;
    localparam logic [31:0] RESV = 32'h0000_2281;
`ifdef AES_SHADOW_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_data_i = '0;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        reg_ack_i = 1'b0;
    logic        reg_err_update_i = 1'b0;
    logic [31:0] reg_rdata_i = '0;
    logic        done_o;
    logic [1:0]  status_o;
    logic [31:0] committed_o;

    aes_ctrl_shadow_writer #(.TimeoutCycles(TO)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_data_i       (req_data_i),
        .reg_we_o         (reg_we_o),
        .reg_wdata_o      (reg_wdata_o),
        .reg_ack_i        (reg_ack_i),
        .reg_err_update_i (reg_err_update_i),
        .reg_rdata_i      (reg_rdata_i),
        .done_o           (done_o),
        .status_o         (status_o),
        .committed_o      (committed_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic [31:0] commit;
    } done_exp_t;

    done_exp_t   dq[$];
    int          wq_cyc[$];
    logic [31:0] wq_dat[$];
    logic [31:0] exp_commit = RESV;

    // Monitor: every write strobe and every completion must match a queued expectation.
    initial begin
        done_exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && reg_we_o) begin
                if (wq_cyc.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("write_cycle", cyc, wq_cyc.pop_front());
                    chk("write_data", reg_wdata_o, wq_dat.pop_front());
                end
            end
            if (rst_ni && done_o) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("status", {30'd0, status_o}, {30'd0, e.st});
                    @(negedge clk_i);
                    chk("committed", committed_o, e.commit);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // mode: 0 normal, 1 update error, 2 no acks (timeout), 3 stray acks, 4 readback mismatch,
    //       5 reset during WAIT2
    task automatic run_req(input logic [31:0] d, input int mode, output int acc);
        int        n;
        done_exp_t e;
        n = 0;
        acc = -1;
        while (!req_ready_o && n < 50) begin
            step();
            n++;
        end
        if (!req_ready_o) begin
            chk("ready_wait", 32'd0, 32'd1);
            return;
        end
        if (mode == 3) begin
            reg_ack_i = 1'b1;   // stray ack while idle, no request
            step();
        end
        acc = cyc;
        req_valid_i = 1'b1;
        req_data_i  = d;
        reg_rdata_i = (mode == 4) ? 32'hDEAD_BEEF : d;
        reg_ack_i   = (mode == 3);
        wq_cyc.push_back(acc + 1);
        wq_dat.push_back(d);
        if (mode != 2) begin
            wq_cyc.push_back(acc + 3);
            wq_dat.push_back(d);
        end
        if (mode != 5) begin
            e.cyc = (mode == 2) ? acc + 2 + TO + 1 : acc + 5 + RB;
            case (mode)
                1:       e.st = 2'b01;
                2:       e.st = 2'b10;
                4:       e.st = 2'b11;
                default: e.st = 2'b00;
            endcase
            if (e.st == 2'b00) exp_commit = d;
            e.commit = exp_commit;
            dq.push_back(e);
        end
        step();                         // WR1
        req_valid_i = 1'b0;
        req_data_i  = ~d;               // must not disturb the latched word
        reg_ack_i   = (mode == 3);
        step();                         // WAIT1
        reg_ack_i = (mode != 2);
        step();                         // WR2
        reg_ack_i = 1'b0;
        if (mode == 2) begin
            repeat (8) step();
            return;
        end
        step();                         // WAIT2
        if (mode == 5) begin
            rst_ni = 1'b0;
            @(negedge clk_i);
            chk("rst_mid_we", {31'd0, reg_we_o}, 32'd0);
            chk("rst_mid_ready", {31'd0, req_ready_o}, 32'd1);
            chk("rst_mid_commit", committed_o, RESV);
            chk("rst_mid_done", {31'd0, done_o}, 32'd0);
            step();
            step();
            rst_ni = 1'b1;
            exp_commit = RESV;
            step();
            return;
        end
        reg_ack_i        = 1'b1;
        reg_err_update_i = (mode == 1);
        step();
        reg_ack_i        = 1'b0;
        reg_err_update_i = 1'b0;
        step();
    endtask

    initial begin
        int a0;
        int a1;
        // Reset values
        @(negedge clk_i);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_we", {31'd0, reg_we_o}, 32'd0);
        chk("rst_wdata", reg_wdata_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_status", {30'd0, status_o}, 32'd0);
        chk("rst_commit", committed_o, RESV);
        step();
        rst_ni = 1'b1;
        step();

        run_req(32'h0000_00A5, 0, a0);
        run_req(32'h1234_5678, 1, a1);
        // Back-to-back: next accept on the cycle after DONE.
        chk("back_to_back", a1, a0 + 6 + RB);
        run_req(32'h0BAD_F00D, 2, a0);
        run_req(32'h0000_C3A5, 3, a0);
`ifdef AES_SHADOW_READBACK_EN
        run_req(32'hDEAD_BEEE, 4, a0);
`endif
        run_req(32'hCAFE_0001, 0, a0);
        run_req(32'h5555_AAAA, 5, a0);
        run_req(32'h0F0F_1234, 0, a0);
        repeat (10) step();

        chk("pending_done", dq.size(), 32'd0);
        chk("pending_writes", wq_cyc.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
